two_int_log2: RTL

Inverse of the 2^n block: takes a HALF or SINGLE precision float `a` and returns the signed integer floor(log2(|a|)) as a BITS-wide two's-complement value, with flags for special operands. Normal operands take one cycle. Subnormal operands are normalised iteratively, one shift per cycle. The block sits in the Precision library beside the power-of-two generator and feeds exponent-range and scaling logic.

---
 rtl/two_int_log2_if.sv | 11 +
 rtl/two_int_log2.sv | 88 ++++++++
 2 files changed

// File: rtl/two_int_log2_if.sv
// two_int_log2_if: operand/result handshake bundle for two_int_log2
interface two_int_log2_if #(parameter int BITS = 16);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic            out_valid;
  logic [BITS-1:0] c;
  logic [2:0]      flags;
  modport master (output in_valid, a, input in_ready, out_valid, c, flags);
  modport slave  (input in_valid, a, output in_ready, out_valid, c, flags);
endinterface

// File: rtl/two_int_log2.sv
// two_int_log2: floor(log2|a|) of a HALF/SINGLE float with special-operand flags
module two_int_log2 #(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF"
) (
  input  logic clk,
  input  logic rstn,
  two_int_log2_if.slave io
);
  localparam bit SP   = PRECISION == "SINGLE";
  localparam int EW   = SP ? 8 : 5;
  localparam int MW   = SP ? 23 : 10;
  localparam int BIAS = SP ? 127 : 15;
  localparam int SW   = 5;
  localparam logic [BITS-1:0] MAX_POS = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
  if (!((BITS == 16 && PRECISION == "HALF") || (BITS == 32 && PRECISION == "SINGLE"))) begin : g_bad
    $error("two_int_log2: BITS/PRECISION must be 16/HALF or 32/SINGLE");
  end
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t          state_q, state_d;
  logic [MW-1:0]   sh_q, sh_d;
  logic [SW-1:0]   s_q, s_d;
  logic            neg_q, neg_d;
  logic [BITS-1:0] c_q, c_d;
  logic [2:0]      flags_q, flags_d;
  logic            sgn, acc;
  logic [EW-1:0]   e;
  logic [MW-1:0]   m;
  assign sgn          = io.a[BITS-1];
  assign e            = io.a[BITS-2 -: EW];
  assign m            = io.a[MW-1:0];
  assign io.in_ready  = state_q != NORM;
  assign acc          = io.in_valid && io.in_ready;
  assign io.out_valid = state_q == DONE;
  assign io.c         = c_q;
  assign io.flags     = flags_q;
  always_comb begin
    state_d = state_q == DONE ? IDLE : state_q;
    sh_d    = sh_q;
    s_d     = s_q;
    neg_d   = neg_q;
    c_d     = c_q;
    flags_d = flags_q;
    if (state_q == NORM) begin
      if (sh_q[MW-1]) begin
        state_d = DONE;
        c_d     = -(BITS'(BIAS) + BITS'(s_q));
        flags_d = {neg_q, 2'b00};
      end else begin
        sh_d = sh_q << 1;
        s_d  = s_q + 1'b1;
      end
    end else if (acc) begin
      neg_d   = sgn;
      sh_d    = m;
      s_d     = '0;
      state_d = (e == '0 && m != '0) ? NORM : DONE;
      if (e == '1) begin
        c_d     = m == '0 ? MAX_POS : '0;
        flags_d = {sgn && m == '0, 2'b10};
      end else if (e == '0 && m == '0) begin
        c_d     = MIN_NEG;
        flags_d = {sgn, 2'b01};
      end else if (e != '0) begin
        c_d     = BITS'(e) - BITS'(BIAS);
        flags_d = {sgn, 2'b00};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sh_q    <= '0;
      s_q     <= '0;
      neg_q   <= 1'b0;
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      s_q     <= s_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end
endmodule
